// File: rtl/spi_frame_sequencer.sv
// Control FSM for the SPI memory slave: sequences shift, load, address latch,
// memory write and MISO enable over one address byte plus one data word.
module spi_frame_sequencer #(
  parameter int width = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic cs_n,
  input  logic sclk_rise,
  input  logic sclk_fall,
  input  logic rw_bit,
  output logic sr_shift,
  output logic sr_load,
  output logic addr_we,
  output logic mem_we,
  output logic miso_en,
  output logic busy
);

  localparam int CntW = $clog2(width + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(width - 1);

  typedef enum logic [2:0] {
    StIdle,
    StGetAddr,
    StDecode,
    StReadLoad,
    StReadShift,
    StWriteShift,
    StWriteMem,
    StDone
  } state_t;

  state_t          state;
  state_t          stateNext;
  state_t          doneState;
  logic [CntW-1:0] bitCnt;
  logic [CntW-1:0] cntNext;
  logic            edgeHit;

  always_comb begin
    stateNext = state;
    doneState = state;
    cntNext   = bitCnt;
    edgeHit   = 1'b0;

    unique case (state)
      StIdle:       if (!cs_n) stateNext = StGetAddr;
      StGetAddr: begin
        edgeHit   = sclk_rise;
        doneState = StDecode;
      end
      StDecode:     stateNext = rw_bit ? StReadLoad : StWriteShift;
      StReadLoad:   stateNext = StReadShift;
      StReadShift: begin
        edgeHit   = sclk_fall;
        doneState = StDone;
      end
      StWriteShift: begin
        edgeHit   = sclk_rise;
        doneState = StWriteMem;
      end
      StWriteMem:   stateNext = StDone;
      StDone:       stateNext = state;
      default:      stateNext = StIdle;
    endcase

    // Shifting phases leave on the same edge that performs the final shift.
    if (edgeHit) begin
      if (bitCnt == LastCnt) begin
        stateNext = doneState;
      end else begin
        cntNext = bitCnt + CntW'(1);
      end
    end

    if (cs_n && state != StIdle) begin
      stateNext = StIdle;
    end

    if (stateNext != state) begin
      cntNext = '0;
    end

    sr_shift = edgeHit & ~cs_n;
  end

  // Moore outputs are registered from the next state so they track the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= StIdle;
      bitCnt  <= '0;
      addr_we <= 1'b0;
      sr_load <= 1'b0;
      mem_we  <= 1'b0;
      miso_en <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= stateNext;
      bitCnt  <= cntNext;
      addr_we <= (stateNext == StDecode);
      sr_load <= (stateNext == StReadLoad);
      mem_we  <= (stateNext == StWriteMem);
      miso_en <= (stateNext == StReadShift);
      busy    <= (stateNext != StIdle);
    end
  end

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Scoreboard bench for spi_frame_sequencer: stimulus queues expected strobes,
// a negedge monitor pops and compares them and tallies shift/MISO activity.
module tb_spi_frame_sequencer;

  logic clk = 1'b0;
  logic reset, cs_n, sclk_rise, sclk_fall, rw_bit;
  logic sr_shift, sr_load, addr_we, mem_we, miso_en, busy;

  spi_frame_sequencer #(.width(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .cs_n     (cs_n),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall),
    .rw_bit   (rw_bit),
    .sr_shift (sr_shift),
    .sr_load  (sr_load),
    .addr_we  (addr_we),
    .mem_we   (mem_we),
    .miso_en  (miso_en),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bench model of the slave's shift register, fed by mosi on each sr_shift.
  logic       mosi = 1'b0;
  logic [7:0] sr = 8'h00;
  assign rw_bit = sr[0];

  typedef struct {
    int kind;  // 1 addr_we, 2 sr_load, 3 mem_we
    int cyc;
    int data;
  } ev_t;
  ev_t expQ[$];

  int nCmp = 0;
  int nErr = 0;
  int shiftCnt, misoFall, misoShift, misoCyc;

  task automatic check(input string name, input int act, input int exp);
    nCmp++;
    if (act != exp) begin
      nErr++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic obs(input int kind, input int dataAct);
    ev_t e;
    if (expQ.size() == 0) begin
      nCmp++;
      nErr++;
      $display("FAIL unexpected_strobe: got kind %0d at cycle %0d, required none", kind, cyc);
    end else begin
      e = expQ.pop_front();
      check("strobe_kind", kind, e.kind);
      check("strobe_cycle", cyc, e.cyc);
      if (kind != 2) check("strobe_data", dataAct, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (addr_we) obs(1, int'(sr[7:1]));
      if (sr_load) obs(2, 0);
      if (mem_we)  obs(3, int'(sr));
      if (sr_shift) shiftCnt++;
      if (miso_en) misoCyc++;
      if (miso_en && sclk_fall) misoFall++;
      if (miso_en && sr_shift) misoShift++;
      if (sr_shift) sr = {sr[6:0], mosi};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clrCnt();
    shiftCnt  = 0;
    misoFall  = 0;
    misoShift = 0;
    misoCyc   = 0;
  endtask

  task automatic selectLow();
    cs_n = 1'b0;
    tick();
    tick();
  endtask

  // One SCLK period: rise pulse, two idle clocks, fall pulse, two idle clocks.
  task automatic sendBits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = v[i];
      sclk_rise = 1'b1; tick();
      sclk_rise = 1'b0; tick(); tick();
      sclk_fall = 1'b1; tick();
      sclk_fall = 1'b0; tick(); tick();
    end
  endtask

  task automatic writeFrame(input logic [7:0] addrByte, input logic [15:0] dataBits,
                            input int nData, input int expData);
    int t;
    t = cyc;
    expQ.push_back('{kind: 1, cyc: t + 43, data: int'(addrByte[7:1])});
    sendBits({8'h00, addrByte}, 8);
    t = cyc;
    expQ.push_back('{kind: 3, cyc: t + 43, data: expData});
    sendBits(dataBits, nData);
  endtask

  task automatic readAddr(input logic [7:0] addrByte);
    int t;
    t = cyc;
    expQ.push_back('{kind: 1, cyc: t + 43, data: int'(addrByte[7:1])});
    expQ.push_back('{kind: 2, cyc: t + 44, data: 0});
    sendBits({8'h00, addrByte}, 8);
  endtask

  task automatic drained(input string name);
    tick(); tick();
    check(name, expQ.size(), 0);
  endtask

  task automatic readFrameChecks(input string tag);
    clrCnt();
    selectLow();
    readAddr(8'h55);
    sendBits(16'h00A5, 8);
    tick(); tick();
    cs_n = 1'b1;
    tick();
    check({tag, "_busy_after_cs"}, int'(busy), 0);
    check({tag, "_shift_count"}, shiftCnt, 16);
    check({tag, "_miso_falls"}, misoFall, 8);
    check({tag, "_miso_shifts"}, misoShift, 8);
    drained({tag, "_queue_empty"});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cs_n = 1'b1; sclk_rise = 1'b0; sclk_fall = 1'b0;
    tick(); tick();
    check("reset_sr_shift", int'(sr_shift), 0);
    check("reset_sr_load", int'(sr_load), 0);
    check("reset_addr_we", int'(addr_we), 0);
    check("reset_mem_we", int'(mem_we), 0);
    check("reset_miso_en", int'(miso_en), 0);
    check("reset_busy", int'(busy), 0);
    reset = 1'b0;
    tick();

    // Write frame: addr 0x2A write, data 0xC3.
    clrCnt();
    cs_n = 1'b0;
    tick();
    check("wr_busy_rise", int'(busy), 1);
    tick();
    writeFrame(8'h54, 16'h00C3, 8, 8'hC3);
    tick(); tick();
    cs_n = 1'b1;
    tick();
    check("wr_busy_fall", int'(busy), 0);
    check("wr_shift_count", shiftCnt, 16);
    check("wr_miso_never", misoCyc, 0);
    drained("wr_queue_empty");

    // Read frame.
    readFrameChecks("rd");

    // Abort after 5 address rises, then a clean write frame.
    clrCnt();
    selectLow();
    sendBits(16'h0054, 5);
    check("abort_busy_before", int'(busy), 1);
    cs_n = 1'b1;
    tick();
    check("abort_busy", int'(busy), 0);
    check("abort_shift_count", shiftCnt, 5);
    tick();
    clrCnt();
    selectLow();
    writeFrame(8'h3C, 16'h005A, 8, 8'h5A);
    tick();
    cs_n = 1'b1;
    tick();
    check("abort_next_shift_count", shiftCnt, 16);
    drained("abort_queue_empty");

    // Reset during READ_SHIFT after 3 counted falls.
    clrCnt();
    selectLow();
    readAddr(8'h55);
    sendBits(16'h0003, 2);
    check("rst_miso_before", int'(miso_en), 1);
    check("rst_falls_before", misoFall, 3);
    reset = 1'b1;
    #1;
    check("rst_miso_async", int'(miso_en), 0);
    check("rst_busy_async", int'(busy), 0);
    cs_n = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    drained("rst_queue_empty");
    readFrameChecks("rd_after_rst");

    // Extra rises after the frame completes are ignored.
    clrCnt();
    selectLow();
    writeFrame(8'h54, 16'h0C3A, 12, 8'hC3);
    check("extra_shift_count", shiftCnt, 16);
    check("extra_busy_in_done", int'(busy), 1);
    cs_n = 1'b1;
    tick();
    check("extra_busy_fall", int'(busy), 0);
    drained("extra_queue_empty");

    // Back-to-back frames with a one-clock deselect.
    clrCnt();
    selectLow();
    writeFrame(8'h54, 16'h00C3, 8, 8'hC3);
    tick();
    cs_n = 1'b1;
    tick();
    selectLow();
    writeFrame(8'h3C, 16'h005A, 8, 8'h5A);
    tick();
    cs_n = 1'b1;
    tick();
    check("b2b_shift_count", shiftCnt, 32);
    drained("b2b_queue_empty");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
